draw_scheduler: RTL and testbench

- Per-frame sequencer that shares the single VGA-adapter plot port between the wall drawing engine and the bird drawing engine.
- On each frame tick it runs the fixed phase order: erase wall, erase bird, update positions, draw wall, draw bird.
- Each engine gets a one-cycle start, the scheduler routes that engine's pixel stream to the VGA port and waits for its done pulse.
- It also handles game-over on collision and restart on the go key; it sits between the bird/wall datapaths and the VGA adapter.

---
 rtl/draw_scheduler_pkg.sv | 31 +++
 rtl/draw_scheduler_if.sv | 59 +++++
 rtl/draw_scheduler_pixel_mux_reg.sv | 39 +++
 rtl/draw_scheduler.sv | 128 ++++++++++++
 tb/tb_draw_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/draw_scheduler_pkg.sv
// Shared definitions for the per-frame draw scheduler: state encodings,
// pixel field widths and client indices.
package draw_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;

  localparam int WALL = 0;
  localparam int BIRD = 1;

  typedef enum logic [2:0] {
    WAIT_GO = 3'd0,
    IDLE    = 3'd1,
    E_WALL  = 3'd2,
    E_BIRD  = 3'd3,
    UPDATE  = 3'd4,
    D_WALL  = 3'd5,
    D_BIRD  = 3'd6,
    OVER    = 3'd7
  } state_t;

  function automatic logic is_engine(input state_t s);
    return (s == E_WALL) || (s == E_BIRD) || (s == D_WALL) || (s == D_BIRD);
  endfunction

  function automatic logic is_erase(input state_t s);
    return (s == E_WALL) || (s == E_BIRD);
  endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// Signal bundle between the scheduler, the two drawing engines, the
// datapaths and the VGA adapter.
interface draw_scheduler_if;
  import draw_pkg::*;

  logic             frame_tick;
  logic             go;
  logic             collision;

  logic             wall_start;
  logic             wall_erase;
  logic             wall_done;
  logic [X_W-1:0]   wall_x;
  logic [Y_W-1:0]   wall_y;
  logic [C_W-1:0]   wall_colour;
  logic             wall_plot;

  logic             bird_start;
  logic             bird_erase;
  logic             bird_done;
  logic [X_W-1:0]   bird_x;
  logic [Y_W-1:0]   bird_y;
  logic [C_W-1:0]   bird_colour;
  logic             bird_plot;

  logic             update_en;
  logic             restart;

  logic [X_W-1:0]   vga_x;
  logic [Y_W-1:0]   vga_y;
  logic [C_W-1:0]   vga_colour;
  logic             vga_plot;

  logic             game_over;
  logic             busy;
  logic             frame_overrun;
  logic             timeout_err;

  modport master (
    input  frame_tick, go, collision,
    input  wall_done, wall_x, wall_y, wall_colour, wall_plot,
    input  bird_done, bird_x, bird_y, bird_colour, bird_plot,
    output wall_start, wall_erase, bird_start, bird_erase,
    output update_en, restart,
    output vga_x, vga_y, vga_colour, vga_plot,
    output game_over, busy, frame_overrun, timeout_err
  );

  modport slave (
    output frame_tick, go, collision,
    output wall_done, wall_x, wall_y, wall_colour, wall_plot,
    output bird_done, bird_x, bird_y, bird_colour, bird_plot,
    input  wall_start, wall_erase, bird_start, bird_erase,
    input  update_en, restart,
    input  vga_x, vga_y, vga_colour, vga_plot,
    input  game_over, busy, frame_overrun, timeout_err
  );

endinterface

// File: rtl/draw_scheduler_pixel_mux_reg.sv
// Registered two-client pixel mux; erase phases force the background colour.
module pixel_mux_reg
  import draw_pkg::*;
#(
  parameter logic [C_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 active,
  input  logic                 sel,
  input  logic                 erase,
  input  logic [1:0][X_W-1:0]  x,
  input  logic [1:0][Y_W-1:0]  y,
  input  logic [1:0][C_W-1:0]  colour,
  input  logic [1:0]           plot,
  output logic [X_W-1:0]       vga_x,
  output logic [Y_W-1:0]       vga_y,
  output logic [C_W-1:0]       vga_colour,
  output logic                 vga_plot
);

  // Outside engine phases only the plot strobe is cleared; coordinates hold.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else if (active) begin
      vga_x      <= x[sel];
      vga_y      <= y[sel];
      vga_colour <= erase ? BG_COLOUR : colour[sel];
      vga_plot   <= plot[sel];
    end else begin
      vga_plot   <= 1'b0;
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Per-frame sequencer sharing the VGA plot port between the wall and bird
// engines: erase wall, erase bird, update, draw wall, draw bird.
module draw_scheduler
  import draw_pkg::*;
#(
  parameter logic [C_W-1:0] BG_COLOUR        = 3'b000,
  parameter int             MAX_PHASE_CYCLES = 4096,
  parameter int             TW               = 13
) (
  input  logic              clk,
  input  logic              resetn,
  draw_scheduler_if.master  bus
);

  localparam logic [TW-1:0] WD_LAST = TW'(MAX_PHASE_CYCLES - 1);

  state_t          state_reg, state_next;
  logic            first_reg;
  logic            go_prev_reg;
  logic            restart_reg;
  logic            overrun_reg;
  logic            timeout_reg;
  logic [TW-1:0]   wd_reg;

  logic go_rise, go_accept, engine, on_wall, on_bird;
  logic done_in, done_ok, wd_hit, advance, busy;

  assign go_rise   = bus.go & ~go_prev_reg;
  assign go_accept = go_rise && ((state_reg == WAIT_GO) || (state_reg == OVER));
  assign engine    = is_engine(state_reg);
  assign on_wall   = (state_reg == E_WALL) || (state_reg == D_WALL);
  assign on_bird   = (state_reg == E_BIRD) || (state_reg == D_BIRD);
  assign busy      = engine || (state_reg == UPDATE);

  // The done of the engine not currently owning the port is never looked at.
  assign done_in = on_wall ? bus.wall_done : bus.bird_done;
  assign done_ok = engine && !first_reg && done_in;
  assign wd_hit  = engine && (wd_reg == WD_LAST);
  assign advance = done_ok || wd_hit;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      WAIT_GO: if (go_rise)        state_next = IDLE;
      IDLE:    if (bus.frame_tick) state_next = E_WALL;
      E_WALL:  if (advance)        state_next = E_BIRD;
      E_BIRD:  if (advance)        state_next = UPDATE;
      UPDATE:                      state_next = D_WALL;
      D_WALL:  if (advance)        state_next = D_BIRD;
      D_BIRD: begin
        if (done_ok)     state_next = bus.collision ? OVER : IDLE;
        else if (wd_hit) state_next = IDLE;
      end
      OVER:    if (go_rise)        state_next = IDLE;
      default:                     state_next = WAIT_GO;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= WAIT_GO;
      first_reg   <= 1'b0;
      go_prev_reg <= 1'b0;
      restart_reg <= 1'b0;
      overrun_reg <= 1'b0;
      timeout_reg <= 1'b0;
      wd_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      first_reg   <= (state_next != state_reg);
      go_prev_reg <= bus.go;
      restart_reg <= go_accept;
      wd_reg      <= ((state_next != state_reg) || !engine) ? '0 : wd_reg + TW'(1);
      if (go_accept)
        overrun_reg <= 1'b0;
      else if (bus.frame_tick && busy)
        overrun_reg <= 1'b1;
      if (go_accept)
        timeout_reg <= 1'b0;
      else if (wd_hit && !done_ok)
        timeout_reg <= 1'b1;
    end
  end

  assign bus.wall_start    = first_reg && on_wall;
  assign bus.bird_start    = first_reg && on_bird;
  assign bus.wall_erase    = (state_reg == E_WALL);
  assign bus.bird_erase    = (state_reg == E_BIRD);
  assign bus.update_en     = (state_reg == UPDATE);
  assign bus.restart       = restart_reg;
  assign bus.game_over     = (state_reg == OVER);
  assign bus.busy          = busy;
  assign bus.frame_overrun = overrun_reg;
  assign bus.timeout_err   = timeout_reg;

  logic [1:0][X_W-1:0] x_bus;
  logic [1:0][Y_W-1:0] y_bus;
  logic [1:0][C_W-1:0] c_bus;
  logic [1:0]          p_bus;

  assign x_bus[WALL] = bus.wall_x;
  assign x_bus[BIRD] = bus.bird_x;
  assign y_bus[WALL] = bus.wall_y;
  assign y_bus[BIRD] = bus.bird_y;
  assign c_bus[WALL] = bus.wall_colour;
  assign c_bus[BIRD] = bus.bird_colour;
  assign p_bus[WALL] = bus.wall_plot;
  assign p_bus[BIRD] = bus.bird_plot;

  pixel_mux_reg #(
    .BG_COLOUR (BG_COLOUR)
  ) u_mux (
    .clk        (clk),
    .resetn     (resetn),
    .active     (engine),
    .sel        (on_wall ? 1'(WALL) : 1'(BIRD)),
    .erase      (is_erase(state_reg)),
    .x          (x_bus),
    .y          (y_bus),
    .colour     (c_bus),
    .plot       (p_bus),
    .vga_x      (bus.vga_x),
    .vga_y      (bus.vga_y),
    .vga_colour (bus.vga_colour),
    .vga_plot   (bus.vga_plot)
  );

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: stimulus pushes expected events and
// status checks; a negedge monitor pops and compares them.
module tb_draw_scheduler;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  draw_scheduler_if bus();

  draw_scheduler #(
    .BG_COLOUR        (3'b000),
    .MAX_PHASE_CYCLES (4096),
    .TW               (13)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  localparam logic [3:0] K_RST = 4'd1, K_WS = 4'd2, K_BS = 4'd3, K_UPD = 4'd4, K_PIX = 4'd5;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic [23:0] exp_q[$];
  chk_t        chk_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic wall_done_auto, bird_done_auto, wall_done_man, bird_done_man;
  logic wall_auto, bird_auto;
  assign bus.wall_done = wall_done_auto | wall_done_man;
  assign bus.bird_done = bird_done_auto | bird_done_man;

  function automatic logic [23:0] ev(input logic [3:0] k, input logic e,
                                     input logic [7:0] x, input logic [6:0] y,
                                     input logic [2:0] c);
    return {1'b0, k, e, x, y, c};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic see(input logic [23:0] got, input string what);
    logic [23:0] e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event %h, nothing expected", what, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: got event %h, expected %h", what, got, e);
      end else begin
        $display("[TB] event %s %h ok", what, got);
      end
    end
  endtask

  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      chk_t c;
      c = chk_q.pop_front();
      n_tests++;
      if (c.act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d", c.name, c.act, c.exp);
      end else begin
        $display("[TB] check %s = %0d ok", c.name, c.act);
      end
    end
    if (bus.restart)    see(ev(K_RST, 1'b0, 8'd0, 7'd0, 3'd0), "restart");
    if (bus.wall_start) see(ev(K_WS, bus.wall_erase, 8'd0, 7'd0, 3'd0), "wall_start");
    if (bus.bird_start) see(ev(K_BS, bus.bird_erase, 8'd0, 7'd0, 3'd0), "bird_start");
    if (bus.update_en)  see(ev(K_UPD, 1'b0, 8'd0, 7'd0, 3'd0), "update_en");
    if (bus.vga_plot)   see(ev(K_PIX, 1'b0, bus.vga_x, bus.vga_y, bus.vga_colour), "pixel");
  end

  // ---------------- engine responders: done 10 cycles after start ----------------
  initial begin
    int wcnt, bcnt;
    wcnt = 0;
    bcnt = 0;
    wall_done_auto = 1'b0;
    bird_done_auto = 1'b0;
    forever begin
      @(posedge clk); #1;
      wall_done_auto = 1'b0;
      bird_done_auto = 1'b0;
      if (!resetn) begin
        wcnt = 0;
        bcnt = 0;
      end else begin
        if (bus.wall_start) wcnt = 10;
        else if (wcnt > 0) begin
          wcnt--;
          if (wcnt == 0 && wall_auto) wall_done_auto = 1'b1;
        end
        if (bus.bird_start) bcnt = 10;
        else if (bcnt > 0) begin
          bcnt--;
          if (bcnt == 0 && bird_auto) bird_done_auto = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic go_pulse();
    bus.go = 1'b1;
    repeat (3) step();
    bus.go = 1'b0;
    step();
  endtask

  task automatic push_frame(input bit with_pix);
    exp_q.push_back(ev(K_WS, 1'b1, 8'd0, 7'd0, 3'd0));
    if (with_pix) exp_q.push_back(ev(K_PIX, 1'b0, 8'd20, 7'd50, 3'b000));
    exp_q.push_back(ev(K_BS, 1'b1, 8'd0, 7'd0, 3'd0));
    exp_q.push_back(ev(K_UPD, 1'b0, 8'd0, 7'd0, 3'd0));
    exp_q.push_back(ev(K_WS, 1'b0, 8'd0, 7'd0, 3'd0));
    if (with_pix) exp_q.push_back(ev(K_PIX, 1'b0, 8'd20, 7'd50, 3'b101));
    exp_q.push_back(ev(K_BS, 1'b0, 8'd0, 7'd0, 3'd0));
  endtask

  // sel: 0 erase-wall start, 1 draw-wall start, 2 draw-bird start, 3 not busy
  task automatic wait_for(input int sel, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      case (sel)
        0:       hit = bus.wall_start && bus.wall_erase;
        1:       hit = bus.wall_start && !bus.wall_erase;
        2:       hit = bus.bird_start && !bus.bird_erase;
        default: hit = !bus.busy;
      endcase
      if (hit) break;
      step();
    end
    if (!hit) chk({"wait_", name}, 32'd0, 32'd1);
  endtask

  task automatic drive_pixel();
    bus.wall_x = 8'd20; bus.wall_y = 7'd50; bus.wall_colour = 3'b101; bus.wall_plot = 1'b1;
    bus.bird_x = 8'd99; bus.bird_y = 7'd9;  bus.bird_colour = 3'b011; bus.bird_plot = 1'b1;
    step();
    bus.wall_plot = 1'b0;
    step();
    bus.bird_plot = 1'b0;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int n;
    bit seen;
    bus.frame_tick = 1'b0; bus.go = 1'b0; bus.collision = 1'b0;
    bus.wall_x = '0; bus.wall_y = '0; bus.wall_colour = '0; bus.wall_plot = 1'b0;
    bus.bird_x = '0; bus.bird_y = '0; bus.bird_colour = '0; bus.bird_plot = 1'b0;
    wall_done_man = 1'b0; bird_done_man = 1'b0;
    wall_auto = 1'b1; bird_auto = 1'b1;

    #1 resetn = 1'b0;
    repeat (3) step();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_game_over", 32'(bus.game_over), 32'd0);
    chk("rst_vga_plot", 32'(bus.vga_plot), 32'd0);
    chk("rst_flags", 32'({bus.frame_overrun, bus.timeout_err}), 32'd0);
    resetn = 1'b1;
    step();

    // WAIT_GO ignores frame ticks; a held go gives exactly one restart
    pulse_tick();
    repeat (3) step();
    exp_q.push_back(ev(K_RST, 1'b0, 8'd0, 7'd0, 3'd0));
    go_pulse();
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_vga", 32'({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot}), 32'd0);

    // normal frame and busy release timing
    push_frame(1'b0);
    pulse_tick();
    wait_for(2, "dbird1");
    repeat (10) step();
    chk("busy_at_bird_done", 32'(bus.busy), 32'd1);
    step();
    chk("busy_after_bird_done", 32'(bus.busy), 32'd0);
    chk("no_overrun_normal", 32'(bus.frame_overrun), 32'd0);

    // pixel routing, erase colour override, bird plot not forwarded
    push_frame(1'b1);
    pulse_tick();
    wait_for(0, "ewall2");
    drive_pixel();
    wait_for(1, "dwall2");
    drive_pixel();
    wait_for(2, "dbird2");
    wait_for(3, "idle2");

    // collision on bird_done -> OVER; ticks ignored there
    push_frame(1'b0);
    bus.collision = 1'b1;
    pulse_tick();
    wait_for(2, "dbird3");
    wait_for(3, "over3");
    bus.collision = 1'b0;
    chk("game_over_set", 32'(bus.game_over), 32'd1);
    pulse_tick();
    repeat (3) step();
    pulse_tick();
    repeat (3) step();
    chk("over_tick_no_overrun", 32'(bus.frame_overrun), 32'd0);
    chk("over_still", 32'(bus.game_over), 32'd1);
    exp_q.push_back(ev(K_RST, 1'b0, 8'd0, 7'd0, 3'd0));
    go_pulse();
    chk("game_over_cleared", 32'(bus.game_over), 32'd0);

    // overrun during D_WALL plus a wall engine that never finishes
    push_frame(1'b0);
    pulse_tick();
    wait_for(1, "dwall4");
    wall_auto = 1'b0;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      step();
      n++;
      bus.frame_tick = (n == 2);
      if (bus.bird_start) begin
        seen = 1'b1;
        break;
      end
    end
    bus.frame_tick = 1'b0;
    wall_auto = 1'b1;
    chk("timeout_advanced", 32'(seen), 32'd1);
    chk("timeout_cycles", 32'(n), 32'd4096);
    chk("timeout_err_set", 32'(bus.timeout_err), 32'd1);
    chk("overrun_set", 32'(bus.frame_overrun), 32'd1);
    wait_for(3, "idle4");
    go_pulse();
    chk("overrun_sticky", 32'(bus.frame_overrun), 32'd1);
    chk("timeout_sticky", 32'(bus.timeout_err), 32'd1);

    // reach OVER, then go clears both flags
    push_frame(1'b0);
    bus.collision = 1'b1;
    pulse_tick();
    wait_for(2, "dbird5");
    wait_for(3, "over5");
    bus.collision = 1'b0;
    chk("over5_game_over", 32'(bus.game_over), 32'd1);
    exp_q.push_back(ev(K_RST, 1'b0, 8'd0, 7'd0, 3'd0));
    go_pulse();
    chk("flags_cleared", 32'({bus.frame_overrun, bus.timeout_err}), 32'd0);

    // asynchronous reset in the middle of D_BIRD
    push_frame(1'b0);
    bus.bird_x = 8'd99; bus.bird_y = 7'd9; bus.bird_colour = 3'b011;
    pulse_tick();
    wait_for(2, "dbird6");
    bird_auto = 1'b0;
    repeat (3) step();
    #2 resetn = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_vga", 32'({bus.vga_x, bus.vga_y, bus.vga_colour, bus.vga_plot}), 32'd0);
    chk("arst_starts", 32'({bus.wall_start, bus.bird_start, bus.wall_erase, bus.bird_erase}), 32'd0);
    repeat (2) step();
    resetn = 1'b1;
    step();
    bird_done_man = 1'b1;
    step();
    bird_done_man = 1'b0;
    step();
    chk("late_done_ignored", 32'({bus.busy, bus.game_over}), 32'd0);
    pulse_tick();
    repeat (3) step();
    bird_auto = 1'b1;
    exp_q.push_back(ev(K_RST, 1'b0, 8'd0, 7'd0, 3'd0));
    go_pulse();
    push_frame(1'b0);
    pulse_tick();
    wait_for(2, "dbird7");
    wait_for(3, "idle7");

    repeat (3) step();
    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
